// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-0 responder over a 32x8 register file with a local host port
// Optional feature macro: SPI_SLAVE_IRQ_EN (W1C status register and registered irq output).
module spi_slave_regfile #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [4:0] STATUS_ADDR = 5'd25,
    parameter logic [4:0] IEN_ADDR    = 5'd26
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_ss_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [4:0] host_addr,
    input  logic       host_wr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       reg_wr_strobe,
    output logic [4:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;

    logic [7:0] r_regs [32];
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [2:0] r_bit_cnt;
    logic [4:0] r_addr;
    logic       r_dir;
    logic       r_oe;
    logic [7:0] r_host_rdata;
    logic       r_wr_strobe;
    logic [4:0] r_wr_addr;
    logic [7:0] r_wr_data;

    logic       w_sclk_s;
    logic       w_mosi_s;
    logic       w_ss_s;
    logic       w_active;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_ss_fall;
    logic       w_ss_rise;
    logic       w_byte_done;
    logic       w_spi_wr;
    logic [7:0] w_rx_next;
    logic [7:0] w_tx_load;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];

    // SCLK edges only count while a frame is open and select is still low
    assign w_active    = (r_state != ST_IDLE) && !w_ss_s;
    assign w_sclk_rise = w_active && w_sclk_s && !r_sclk_d;
    assign w_sclk_fall = w_active && !w_sclk_s && r_sclk_d;
    assign w_ss_fall   = !w_ss_s && r_ss_d;
    assign w_ss_rise   = w_ss_s && !r_ss_d;
    assign w_rx_next   = {r_rx_shift[6:0], w_mosi_s};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_spi_wr    = w_byte_done && (r_state == ST_DATA) && r_dir;
    assign w_tx_load   = (r_state == ST_CMD) ? r_regs[STATUS_ADDR] :
                         (r_dir ? 8'h00 : r_regs[r_addr]);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_ss_fall) w_state_next = ST_CMD;
            ST_CMD: begin
                if (w_ss_rise)        w_state_next = ST_IDLE;
                else if (w_byte_done) w_state_next = ST_DATA;
            end
            ST_DATA: if (w_ss_rise) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_addr      <= 5'd0;
            r_dir       <= 1'b0;
            r_oe        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_ss_rise) begin
                r_oe       <= 1'b0;
                r_tx_shift <= 8'h00;
                r_bit_cnt  <= 3'd0;
            end else if ((r_state == ST_IDLE) && w_ss_fall) begin
                r_oe       <= 1'b1;
                r_tx_shift <= r_regs[STATUS_ADDR];
                r_bit_cnt  <= 3'd0;
            end else begin
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_next;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (w_byte_done && (r_state == ST_CMD)) begin
                        r_addr <= w_rx_next[7:3];
                        r_dir  <= w_rx_next[1];
                    end
                    if (w_spi_wr) begin
                        r_wr_strobe <= 1'b1;
                        r_wr_addr   <= r_addr;
                        r_wr_data   <= w_rx_next;
                    end
                end
                // Sampling the regfile at this fall makes same-frame writes visible to later reads
                if (w_sclk_fall) begin
                    if (r_bit_cnt == 3'd0) r_tx_shift <= w_tx_load;
                    else                   r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
            end
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic [7:0] w_status_next;
    logic       w_status_hit;
    logic       r_irq;

    always_comb begin
        w_status_next = r_regs[STATUS_ADDR];
        if (w_spi_wr && (r_addr == STATUS_ADDR)) w_status_next = w_status_next & ~w_rx_next;
        if (host_wr && (host_addr == STATUS_ADDR)) w_status_next = w_status_next | host_wdata;
    end

    assign w_status_hit = (w_spi_wr && (r_addr == STATUS_ADDR)) ||
                          (host_wr && (host_addr == STATUS_ADDR));

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_regs[STATUS_ADDR] & r_regs[IEN_ADDR]);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // SPI write is ordered after the host write so it wins on an address collision
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 8'h00;
            r_host_rdata <= 8'h00;
        end else begin
            r_host_rdata <= r_regs[host_addr];
            if (host_wr) r_regs[host_addr] <= host_wdata;
            if (w_spi_wr) r_regs[r_addr] <= w_rx_next;
`ifdef SPI_SLAVE_IRQ_EN
            if (w_status_hit) r_regs[STATUS_ADDR] <= w_status_next;
`endif
        end
    end

    assign spi_miso      = r_oe & r_tx_shift[7];
    assign spi_miso_oe   = r_oe;
    assign host_rdata    = r_host_rdata;
    assign reg_wr_strobe = r_wr_strobe;
    assign reg_wr_addr   = r_wr_addr;
    assign reg_wr_data   = r_wr_data;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - directed self-checking bench for spi_slave_regfile
module tb_spi_slave_regfile;

    localparam int HALF = 8;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [4:0] host_addr;
    logic       host_wr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       reg_wr_strobe;
    logic [4:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       irq;

    int         checks = 0;
    int         failures = 0;
    int         strobe_cnt = 0;
    logic [4:0] last_wr_addr;
    logic [7:0] last_wr_data;
    logic       oe_seen;
    logic [7:0] f_tx [4];
    logic [7:0] f_rx [4];
    logic [7:0] rd;

    always #5 clk_clk = ~clk_clk;

    spi_slave_regfile #(
        .SYNC_STAGES(2),
        .STATUS_ADDR(5'd25),
        .IEN_ADDR   (5'd26)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_ss_n     (spi_ss_n),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .host_addr    (host_addr),
        .host_wr      (host_wr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .reg_wr_strobe(reg_wr_strobe),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .irq          (irq)
    );

    always @(negedge clk_clk) begin
        if (reg_wr_strobe === 1'b1) begin
            strobe_cnt++;
            last_wr_addr = reg_wr_addr;
            last_wr_data = reg_wr_data;
        end
        if (spi_miso_oe === 1'b1) oe_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_wr    = 1'b1;
        cyc(1);
        host_wr    = 1'b0;
    endtask

    task automatic host_read(input logic [4:0] a, output logic [7:0] d);
        host_addr = a;
        cyc(1);
        d = host_rdata;
    endtask

    task automatic do_reset();
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
        host_addr = 5'd0; host_wr = 1'b0; host_wdata = 8'h00;
        reset_reset_n = 1'b0;
        cyc(3);
        reset_reset_n = 1'b1;
        cyc(2);
    endtask

    // Optional collision drives host_wr in exactly the cycle the last data bit commits
    task automatic spi_byte(input logic [7:0] tb, output logic [7:0] rb,
                            input logic collide, input logic [4:0] ca, input logic [7:0] cd);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tb[i];
            cyc(HALF);
            spi_sclk = 1'b1;
            rb[i] = spi_miso;
            if (collide && i == 0) begin
                cyc(2);
                host_addr = ca; host_wdata = cd; host_wr = 1'b1;
                cyc(1);
                host_wr = 1'b0;
                checks++;
                if (reg_wr_strobe !== 1'b1) begin
                    failures++;
                    $display("FAIL collide_same_cycle strobe=%b expected=1", reg_wr_strobe);
                end
                cyc(HALF - 3);
            end else begin
                cyc(HALF);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n, input logic collide, input logic [4:0] ca, input logic [7:0] cd);
        logic [7:0] rb;
        spi_ss_n = 1'b0;
        cyc(HALF);
        for (int b = 0; b < n; b++) begin
            spi_byte(f_tx[b], rb, collide && (b == n - 1), ca, cd);
            f_rx[b] = rb;
        end
        cyc(HALF);
        spi_ss_n = 1'b1;
        cyc(6);
    endtask

    task automatic test_reset();
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
        host_addr = 5'd0; host_wr = 1'b0; host_wdata = 8'h00;
        reset_reset_n = 1'b0;
        cyc(3);
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
        checks++; if (host_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", host_rdata); end
        checks++; if (reg_wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", reg_wr_strobe); end
        checks++; if (reg_wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", reg_wr_addr); end
        checks++; if (reg_wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", reg_wr_data); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset_reset_n = 1'b1;
        cyc(2);
        host_read(5'd25, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_reg25 got=%h exp=00", rd); end
    endtask

    task automatic test_host_rw();
        oe_seen = 1'b0;
        host_write(5'd5, 8'hA7);
        host_read(5'd5, rd);
        checks++; if (rd !== 8'hA7) begin failures++; $display("FAIL host_rw_reg5 got=%h exp=a7", rd); end
        host_read(5'd6, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL host_rw_reg6 got=%h exp=00", rd); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL host_rw_oe got=%b exp=0", oe_seen); end
    endtask

    task automatic test_spi_write();
        strobe_cnt = 0;
        f_tx[0] = 8'h2A; f_tx[1] = 8'h3C;
        spi_frame(2, 1'b0, 5'd0, 8'h00);
        checks++; if (strobe_cnt !== 1) begin failures++; $display("FAIL spi_write_strobes got=%0d exp=1", strobe_cnt); end
        checks++; if (last_wr_addr !== 5'd5) begin failures++; $display("FAIL spi_write_addr got=%0d exp=5", last_wr_addr); end
        checks++; if (last_wr_data !== 8'h3C) begin failures++; $display("FAIL spi_write_data got=%h exp=3c", last_wr_data); end
        checks++; if (f_rx[0] !== 8'h00) begin failures++; $display("FAIL spi_write_status_byte got=%h exp=00", f_rx[0]); end
        checks++; if (f_rx[1] !== 8'h00) begin failures++; $display("FAIL spi_write_tx_zero got=%h exp=00", f_rx[1]); end
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL spi_write_oe_after got=%b exp=0", spi_miso_oe); end
        host_read(5'd5, rd);
        checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL spi_write_reg5 got=%h exp=3c", rd); end
    endtask

    task automatic test_spi_read();
        host_write(5'd9, 8'h5E);
        host_write(5'd25, 8'h81);
        strobe_cnt = 0;
        f_tx[0] = 8'h48; f_tx[1] = 8'h00; f_tx[2] = 8'h00;
        spi_frame(3, 1'b0, 5'd0, 8'h00);
        checks++; if (f_rx[0] !== 8'h81) begin failures++; $display("FAIL spi_read_byte0 got=%h exp=81", f_rx[0]); end
        checks++; if (f_rx[1] !== 8'h5E) begin failures++; $display("FAIL spi_read_byte1 got=%h exp=5e", f_rx[1]); end
        checks++; if (f_rx[2] !== 8'h5E) begin failures++; $display("FAIL spi_read_byte2 got=%h exp=5e", f_rx[2]); end
        checks++; if (strobe_cnt !== 0) begin failures++; $display("FAIL spi_read_strobes got=%0d exp=0", strobe_cnt); end
    endtask

    task automatic test_abort();
        logic [7:0] rb;
        host_write(5'd2, 8'h33);
        strobe_cnt = 0;
        spi_ss_n = 1'b0;
        cyc(HALF);
        spi_byte(8'h12, rb, 1'b0, 5'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b1;
            cyc(HALF);
            spi_sclk = 1'b1;
            cyc(HALF);
            spi_sclk = 1'b0;
        end
        cyc(HALF);
        checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL abort_oe_in_frame got=%b exp=1", spi_miso_oe); end
        spi_ss_n = 1'b1;
        cyc(4);
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL abort_oe_off got=%b exp=0", spi_miso_oe); end
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL abort_miso_off got=%b exp=0", spi_miso); end
        cyc(4);
        checks++; if (strobe_cnt !== 0) begin failures++; $display("FAIL abort_strobes got=%0d exp=0", strobe_cnt); end
        host_read(5'd2, rd);
        checks++; if (rd !== 8'h33) begin failures++; $display("FAIL abort_reg2 got=%h exp=33", rd); end
        f_tx[0] = 8'h12; f_tx[1] = 8'h77;
        spi_frame(2, 1'b0, 5'd0, 8'h00);
        checks++; if (strobe_cnt !== 1) begin failures++; $display("FAIL abort_next_strobes got=%0d exp=1", strobe_cnt); end
        host_read(5'd2, rd);
        checks++; if (rd !== 8'h77) begin failures++; $display("FAIL abort_next_reg2 got=%h exp=77", rd); end
    endtask

    task automatic test_back_to_back_collision();
        f_tx[0] = 8'h2A; f_tx[1] = 8'h22;
        spi_frame(2, 1'b1, 5'd5, 8'h11);
        host_read(5'd5, rd);
        checks++; if (rd !== 8'h22) begin failures++; $display("FAIL collide_reg5 got=%h exp=22", rd); end
    endtask

    task automatic test_irq();
        do_reset();
        host_write(5'd25, 8'h04);
        host_write(5'd26, 8'h04);
        cyc(2);
`ifdef SPI_SLAVE_IRQ_EN
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
`else
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_off got=%b exp=0", irq); end
`endif
        f_tx[0] = 8'hCA; f_tx[1] = 8'h04;
        spi_frame(2, 1'b0, 5'd0, 8'h00);
        checks++; if (f_rx[0] !== 8'h04) begin failures++; $display("FAIL irq_status_byte got=%h exp=04", f_rx[0]); end
        host_read(5'd25, rd);
`ifdef SPI_SLAVE_IRQ_EN
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL irq_w1c_reg25 got=%h exp=00", rd); end
`else
        checks++; if (rd !== 8'h04) begin failures++; $display("FAIL irq_plain_reg25 got=%h exp=04", rd); end
`endif
        cyc(2);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_cleared got=%b exp=0", irq); end
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_spi_write();
        test_spi_read();
        test_abort();
        test_back_to_back_collision();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI mode-0 responder that gives the SoC's SPI master port (SCLK/MOSI/SS_n out, MISO in) a 32 x 8 register file to talk to.
- Uses the same command framing as the USB host controller: a command byte carrying reg[7:3] and dir bit[1], then data bytes.
- Fabric logic reads and writes the same register file through a local port.
- Used as an on-chip loopback/peripheral target for bring-up of the SPI driver without the external USB chip.

Parameters:
- SYNC_STAGES, 2, flops per synchronizer on spi_sclk, spi_mosi and spi_ss_n (minimum 2).
- STATUS_ADDR, 25, register whose value is shifted out on MISO during the command byte.
- IEN_ADDR, 26, interrupt-enable register (used only with the optional feature).

Ports:
- clk_clk  input  1  system clock; must be at least 8x the SCLK frequency.
- reset_reset_n  input  1  synchronous active-low reset.
- spi_sclk  input  1  SPI clock; idles low.
- spi_mosi  input  1  serial data in.
- spi_ss_n  input  1  active-low select.
- spi_miso  output  1  serial data out.
- spi_miso_oe  output  1  MISO output enable for the top-level tristate.
- host_addr  input  5  local register address.
- host_wr  input  1  local write strobe.
- host_wdata  input  8  local write data.
- host_rdata  output  8  registered read of regfile[host_addr]; 1-cycle latency.
- reg_wr_strobe  output  1  one-cycle pulse when an SPI write commits.
- reg_wr_addr  output  5  address of the committed SPI write.
- reg_wr_data  output  8  data of the committed SPI write.
- irq  output  1  interrupt request.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is synchronous and active-low (reset_reset_n). While reset is low:
  - regfile clears to 0; FSM goes to IDLE; bit_cnt=0.
  - spi_miso=0, spi_miso_oe=0, host_rdata=0, reg_wr_strobe=0, reg_wr_addr=0, reg_wr_data=0, irq=0.
- Synchronization and edge detect:
  - All SPI inputs pass through SYNC_STAGES flops.
  - Rise/fall of SCLK and fall/rise of SS_n are detected on the synchronized signals, each as a one-cycle event.
  - MOSI is sampled from its synchronized copy in the cycle a SCLK rise is detected.
- FSM states:
  - IDLE: waiting for select.
  - CMD: receiving the command byte.
  - DATA: receiving/sending data bytes.
- IDLE -> CMD on SS_n fall:
  - spi_miso_oe=1; tx_shift loaded with regfile[STATUS_ADDR]; spi_miso=tx_shift[7] immediately; bit_cnt=0.
- On each SCLK rise:
  - rx_shift = {rx_shift[6:0], mosi}; bit_cnt increments mod 8.
  - When bit_cnt wraps 7 -> 0, a byte is complete.
- On each SCLK fall:
  - If bit_cnt==0, load tx_shift with the next byte and drive its bit 7.
  - Otherwise shift left and drive the new bit 7.
- Command byte complete (CMD -> DATA):
  - addr=rx[7:3], dir=rx[1]; rx[0] and rx[2] are ignored.
  - The next tx byte is regfile[addr] when dir=0, and 0x00 when dir=1.
- Each data byte complete, dir=1 (write):
  - regfile[addr] <= rx byte.
  - reg_wr_strobe pulses for one cycle, with reg_wr_addr/reg_wr_data valid in that same cycle.
- Each data byte complete, dir=0 (read):
  - No write; the next tx byte is regfile[addr].
- No address auto-increment: repeated data bytes target the same register (FIFO semantics).
- Read data is sampled at the SCLK fall that loads it. A write committed earlier in the same frame is therefore visible.
- SS_n rise in any state:
  - A partial byte is discarded with no write.
  - FSM -> IDLE; spi_miso_oe=0 and spi_miso=0 on the next cycle.
- SS_n rising in CMD after a complete command byte: no effect on the regfile.
- host_wr and an SPI write to the same address in the same cycle: the SPI write wins.
- host_wr to a different address in the same cycle: both writes take effect.
- SCLK edges while SS_n is high are ignored.

Optional Feature:
- Macro: SPI_SLAVE_IRQ_EN.
- Defined:
  - irq is registered and equals |(regfile[STATUS_ADDR] & regfile[IEN_ADDR]), lagging the registers by 1 cycle.
  - An SPI write to STATUS_ADDR is write-1-to-clear.
  - host_wr to STATUS_ADDR ORs host_wdata into the register (sets flags).
  - Simultaneous host set and SPI clear: new = (old & ~spi_data) | host_wdata, so the set wins.
- Undefined:
  - irq is constant 0.
  - STATUS_ADDR is an ordinary read/write register on both ports.

Test Plan:
- Reset, then host_wr addr 5 data 0xA7; then host_addr=5 -> host_rdata=0xA7 one cycle later. spi_miso_oe=0 throughout.
- SPI frame 0x2A,0x3C (write reg 5 = 0x3C) -> one reg_wr_strobe with addr=5, data=0x3C; host read of reg 5 = 0x3C.
- Regfile[9]=0x5E, regfile[25]=0x81; SPI frame 0x48,0x00,0x00 (read reg 9) -> MISO bytes 0x81, 0x5E, 0x5E.
- SS_n deasserted after 4 bits of a data byte in frame 0x12,... -> no reg_wr_strobe; reg 2 unchanged; oe=0 the next cycle. The next frame decodes normally.
- Same-cycle host_wr (addr 5, 0x11) and SPI commit (addr 5, 0x22) -> reg 5 = 0x22.
- With SPI_SLAVE_IRQ_EN: host sets reg 25 = 0x04, IEN = 0x04 -> irq=1. SPI write 0xCA,0x04 -> reg 25 = 0x00, irq=0. Without the macro, irq stays 0 and reg 25 reads 0x04.
